// File: rtl/ervp_memory_fifo_ctrl.sv
// Valid/ready FIFO controller around a 1R1W memory cell with synchronous read and
// write-to-read bypass; the cell's read register doubles as the show-ahead output stage.
module ervp_memory_fifo_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rstnn,
    input  logic                           clear,
    input  logic                           wvalid,
    output logic                           wready,
    input  logic [WIDTH-1:0]               wdata,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [WIDTH-1:0]               rdata,
    output logic [$clog2(DEPTH+2)-1:0]     count,
    output logic                           empty,
    output logic                           full
);

    localparam int unsigned BW_INDEX  = $clog2(DEPTH);
    localparam int unsigned BW_COUNT  = $clog2(DEPTH + 2);
    localparam int unsigned BW_MCOUNT = $clog2(DEPTH + 1);

    logic [BW_INDEX-1:0]  wptr;
    logic [BW_INDEX-1:0]  rptr;
    logic [BW_MCOUNT-1:0] mem_count;
    logic                 out_valid;

    logic [BW_INDEX-1:0]  wptr_nxt;
    logic [BW_INDEX-1:0]  rptr_nxt;
    logic [BW_MCOUNT-1:0] mem_count_nxt;

    logic                 active;
    logic                 mem_full;
    logic                 mem_empty;
    logic                 push;
    logic                 pop;
    logic                 slot_free;
    logic                 fetch;

    // memory cell interface
    logic                 mem_wenable;
    logic [BW_INDEX-1:0]  mem_windex;
    logic [WIDTH-1:0]     mem_wdata;
    logic [WIDTH-1:0]     mem_wpermit;
    logic                 mem_renable;
    logic [BW_INDEX-1:0]  mem_rindex;
    logic [WIDTH-1:0]     mem_array [DEPTH];
    logic [WIDTH-1:0]     rdata_synch;

    // handshake, fetch decision and status outputs
    always_comb begin
        active    = rstnn & ~clear;
        mem_full  = (mem_count == BW_MCOUNT'(DEPTH));
        mem_empty = (mem_count == '0);

        wready    = active & ~mem_full;
        push      = wvalid & wready;
        rvalid    = rstnn & out_valid;
        pop       = rvalid & rready;
        slot_free = ~out_valid | rready;
        fetch     = slot_free & (~mem_empty | push) & active;

        count     = rstnn ? (BW_COUNT'(mem_count) + BW_COUNT'(out_valid)) : '0;
        empty     = (count == '0);
        full      = rstnn & mem_full;
        rdata     = rdata_synch;
    end

    // pointer increment with wrap at DEPTH-1 (DEPTH need not be a power of 2)
    always_comb begin
        wptr_nxt = (wptr == BW_INDEX'(DEPTH - 1)) ? '0 : wptr + BW_INDEX'(1);
        rptr_nxt = (rptr == BW_INDEX'(DEPTH - 1)) ? '0 : rptr + BW_INDEX'(1);

        mem_count_nxt = mem_count;
        if (push && !fetch) begin
            mem_count_nxt = mem_count + BW_MCOUNT'(1);
        end else if (!push && fetch) begin
            mem_count_nxt = mem_count - BW_MCOUNT'(1);
        end
    end

    // memory cell port drive
    always_comb begin
        mem_wenable = push;
        mem_windex  = wptr;
        mem_wdata   = wdata;
        mem_wpermit = '1;
        mem_renable = fetch;
        mem_rindex  = rptr;
    end

    // controller state; clear flushes exactly like reset
    always_ff @(posedge clk) begin
        if (!rstnn || clear) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr_nxt;
            end
            if (fetch) begin
                rptr      <= rptr_nxt;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            mem_count <= mem_count_nxt;
        end
    end

    // memory cell storage: masked write, synchronous read with same-index bypass
    always_ff @(posedge clk) begin
        if (mem_wenable) begin
            mem_array[mem_windex] <= (mem_array[mem_windex] & ~mem_wpermit)
                                   | (mem_wdata & mem_wpermit);
        end
        if (mem_renable) begin
            if (mem_wenable && (mem_windex == mem_rindex)) begin
                rdata_synch <= (mem_array[mem_rindex] & ~mem_wpermit)
                             | (mem_wdata & mem_wpermit);
            end else begin
                rdata_synch <= mem_array[mem_rindex];
            end
        end
    end

endmodule
